// File: rtl/hv_pkg.sv
// rtl/hv_pkg.sv - shared HV constants and fetch FSM state type
package hv_pkg;

    localparam int unsigned DefHvDimension = 512;
    localparam int unsigned DefDataWidth   = 8;
    localparam int unsigned DefAddrWidth   = 8;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/am_class_fetch_if.sv
// rtl/am_class_fetch_if.sv - control, SRAM read port and class-HV stream of the fetch unit
interface am_class_fetch_if
    import hv_pkg::*;
#(
    parameter int unsigned HVDimension = DefHvDimension,
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter int unsigned AddrWidth   = DefAddrWidth
);
    logic                   fetch_start_i;
    logic [DataWidth-1:0]   num_class_i;
    logic [AddrWidth-1:0]   base_addr_i;
    logic                   fetch_busy_o;
    logic                   fetch_done_o;
    logic                   mem_req_o;
    logic [AddrWidth-1:0]   mem_addr_o;
    logic [HVDimension-1:0] mem_rdata_i;
    logic [HVDimension-1:0] class_hv_o;
    logic                   class_hv_valid_o;
    logic                   class_hv_ready_i;

    // Fetch unit side
    modport master (
        input  fetch_start_i, num_class_i, base_addr_i, mem_rdata_i, class_hv_ready_i,
        output fetch_busy_o, fetch_done_o, mem_req_o, mem_addr_o, class_hv_o, class_hv_valid_o
    );

    // Controller, SRAM and AM search side
    modport slave (
        output fetch_start_i, num_class_i, base_addr_i, mem_rdata_i, class_hv_ready_i,
        input  fetch_busy_o, fetch_done_o, mem_req_o, mem_addr_o, class_hv_o, class_hv_valid_o
    );

endinterface

// File: rtl/hv_fifo.sv
// rtl/hv_fifo.sv - first-word-fall-through FIFO for class HVs
module hv_fifo #(
    parameter int unsigned Width = 512,
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head is forced to zero when empty so stale entries never show on the port
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset: entries are only visible once written
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap for any depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Upstream credit accounting must make overflow impossible
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/am_class_fetch.sv
// rtl/am_class_fetch.sv - streams class HVs from SRAM into the AM search stage
module am_class_fetch
    import hv_pkg::*;
#(
    parameter int unsigned HVDimension = DefHvDimension,
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter int unsigned AddrWidth   = DefAddrWidth,
    parameter int unsigned FifoDepth   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    am_class_fetch_if.master  bus
);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    fetch_state_e           state_q;
    logic [DataWidth-1:0]   num_q;
    logic [DataWidth-1:0]   issue_cnt_q;
    logic [DataWidth-1:0]   beat_cnt_q;
    logic [AddrWidth-1:0]   base_q;
    logic                   pending_q;
    logic                   done_q;

    logic                   mem_req;
    logic                   credit_ok;
    logic                   handshake;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CntW-1:0]        fifo_count;
    logic [HVDimension-1:0] fifo_data;

    // A read is allowed only if its data is guaranteed a FIFO slot on return
    assign credit_ok = ((CntW + 1)'(fifo_count) + (CntW + 1)'(pending_q)) < (CntW + 1)'(FifoDepth);
    assign mem_req   = (state_q == FETCH_RUN) && (issue_cnt_q < num_q) && credit_ok;

    // Returning data bypasses an empty FIFO so the first beat appears the cycle it arrives
    assign handshake = bus.class_hv_valid_o && bus.class_hv_ready_i;
    assign fifo_push = pending_q && !(fifo_empty && bus.class_hv_ready_i);
    assign fifo_pop  = !fifo_empty && bus.class_hv_ready_i;

    assign bus.mem_req_o        = mem_req;
    assign bus.mem_addr_o       = mem_req ? base_q + AddrWidth'(issue_cnt_q) : '0;
    assign bus.class_hv_valid_o = !fifo_empty || pending_q;
    assign bus.class_hv_o       = fifo_empty ? (pending_q ? bus.mem_rdata_i : '0) : fifo_data;
    assign bus.fetch_busy_o     = (state_q != FETCH_IDLE);
    assign bus.fetch_done_o     = done_q;

    hv_fifo #(
        .Width (HVDimension),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (bus.mem_rdata_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer: latches the job, counts issued reads and delivered beats, pulses done
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FETCH_IDLE;
            num_q       <= '0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            pending_q <= mem_req;
            case (state_q)
                FETCH_IDLE: begin
                    if (bus.fetch_start_i) begin
                        if (bus.num_class_i != '0) begin
                            state_q     <= FETCH_RUN;
                            num_q       <= bus.num_class_i;
                            base_q      <= bus.base_addr_i;
                            issue_cnt_q <= '0;
                            beat_cnt_q  <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                FETCH_RUN: begin
                    if (mem_req) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                        if (issue_cnt_q == num_q - 1'b1) begin
                            state_q <= FETCH_DRAIN;
                        end
                    end
                    if (handshake) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                FETCH_DRAIN: begin
                    if (handshake) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == num_q - 1'b1) begin
                            state_q <= FETCH_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_am_class_fetch.sv
// tb/tb_am_class_fetch.sv - scoreboard bench for am_class_fetch
module tb_am_class_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   exp_addr_q [$];
    logic [511:0] exp_hv_q   [$];
    int issued  = 0;
    int popped  = 0;
    int beats   = 0;
    int max_occ = 0;

    am_class_fetch_if #(.HVDimension(512), .DataWidth(8), .AddrWidth(8)) bus ();

    am_class_fetch #(
        .HVDimension (512),
        .DataWidth   (8),
        .AddrWidth   (8),
        .FifoDepth   (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] sram_word(input logic [7:0] a);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) begin
            w[i*32 +: 32] = {a, ~a, 8'(i), a ^ 8'(i * 17)};
        end
        return w;
    endfunction

    // SRAM model: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (bus.mem_req_o) bus.mem_rdata_i <= sram_word(bus.mem_addr_o);
        else               bus.mem_rdata_i <= {16{$urandom}};
    end

    // Monitor: read addresses and delivered beats against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_o) begin
                issued++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_read addr=%0h expected no read", bus.mem_addr_o);
                end else begin
                    logic [7:0] ea;
                    ea = exp_addr_q.pop_front();
                    if (bus.mem_addr_o !== ea) begin
                        failures++;
                        $display("FAIL read_addr got=%0h exp=%0h", bus.mem_addr_o, ea);
                    end
                end
            end
            if (issued - popped > max_occ) max_occ = issued - popped;
            if (bus.class_hv_valid_o && bus.class_hv_ready_i) begin
                popped++;
                beats++;
                checks++;
                if (exp_hv_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat data=%0h expected none", bus.class_hv_o[31:0]);
                end else begin
                    logic [511:0] eh;
                    eh = exp_hv_q.pop_front();
                    if (bus.class_hv_o !== eh) begin
                        failures++;
                        $display("FAIL beat_data got=%0h exp=%0h", bus.class_hv_o, eh);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] base, input logic [7:0] num);
        for (int i = 0; i < int'(num); i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            exp_addr_q.push_back(a);
            exp_hv_q.push_back(sram_word(a));
        end
    endtask

    task automatic clear_sb();
        exp_addr_q.delete();
        exp_hv_q.delete();
        issued = 0; popped = 0; beats = 0; max_occ = 0;
    endtask

    task automatic start_fetch(input logic [7:0] base, input logic [7:0] num, input bit expect_beats);
        bus.fetch_start_i = 1'b1;
        bus.num_class_i   = num;
        bus.base_addr_i   = base;
        if (expect_beats) push_exp(base, num);
        tick();
        bus.fetch_start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bus.fetch_done_o) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++; if (bus.fetch_busy_o !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.fetch_busy_o); end
        checks++; if (bus.fetch_done_o !== 1'b0)     begin failures++; $display("FAIL rst_done got=%b exp=0", bus.fetch_done_o); end
        checks++; if (bus.mem_req_o !== 1'b0)        begin failures++; $display("FAIL rst_req got=%b exp=0", bus.mem_req_o); end
        checks++; if (bus.mem_addr_o !== 8'h00)      begin failures++; $display("FAIL rst_addr got=%0h exp=0", bus.mem_addr_o); end
        checks++; if (bus.class_hv_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.class_hv_valid_o); end
        checks++; if (bus.class_hv_o !== '0)         begin failures++; $display("FAIL rst_hv got=%0h exp=0", bus.class_hv_o[31:0]); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit exp_req   [5] = '{1, 1, 1, 0, 0};
        bit exp_valid [5] = '{0, 1, 1, 1, 0};
        bit exp_busy  [5] = '{1, 1, 1, 1, 0};
        bit exp_done  [5] = '{0, 0, 0, 0, 1};
        clear_sb();
        bus.class_hv_ready_i = 1'b1;
        tick();
        start_fetch(8'h10, 8'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (bus.mem_req_o !== exp_req[k])          begin failures++; $display("FAIL basic_req t+%0d got=%b exp=%b", k + 1, bus.mem_req_o, exp_req[k]); end
            checks++; if (bus.class_hv_valid_o !== exp_valid[k]) begin failures++; $display("FAIL basic_valid t+%0d got=%b exp=%b", k + 1, bus.class_hv_valid_o, exp_valid[k]); end
            checks++; if (bus.fetch_busy_o !== exp_busy[k])      begin failures++; $display("FAIL basic_busy t+%0d got=%b exp=%b", k + 1, bus.fetch_busy_o, exp_busy[k]); end
            checks++; if (bus.fetch_done_o !== exp_done[k])      begin failures++; $display("FAIL basic_done t+%0d got=%b exp=%b", k + 1, bus.fetch_done_o, exp_done[k]); end
        end
        checks++; if (beats !== 3)            begin failures++; $display("FAIL basic_beats got=%0d exp=3", beats); end
        checks++; if (exp_hv_q.size() !== 0)  begin failures++; $display("FAIL basic_left got=%0d exp=0", exp_hv_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [511:0] held;
        bit seen;
        clear_sb();
        bus.class_hv_ready_i = 1'b0;
        tick();
        start_fetch(8'h40, 8'd5, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.class_hv_valid_o) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL bp_first_valid got=none exp=valid"); end
        held = bus.class_hv_o;
        checks++; if (held !== sram_word(8'h40)) begin failures++; $display("FAIL bp_head got=%0h exp=%0h", held[31:0], sram_word(8'h40)[31:0]); end
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.class_hv_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid_stall got=%b exp=1", bus.class_hv_valid_o); end
            checks++; if (bus.class_hv_o !== held)       begin failures++; $display("FAIL bp_hv_stable got=%0h exp=%0h", bus.class_hv_o[31:0], held[31:0]); end
        end
        tick();
        bus.class_hv_ready_i = 1'b1;
        wait_done(50, seen);
        checks++; if (!seen)                 begin failures++; $display("FAIL bp_done got=timeout exp=pulse"); end
        checks++; if (beats !== 5)           begin failures++; $display("FAIL bp_beats got=%0d exp=5", beats); end
        checks++; if (max_occ > 2)           begin failures++; $display("FAIL bp_outstanding got=%0d exp<=2", max_occ); end
        checks++; if (exp_hv_q.size() !== 0) begin failures++; $display("FAIL bp_left got=%0d exp=0", exp_hv_q.size()); end
    endtask

    task automatic test_wrap();
        bit seen;
        clear_sb();
        bus.class_hv_ready_i = 1'b1;
        tick();
        start_fetch(8'hFE, 8'd4, 1'b1);
        wait_done(50, seen);
        checks++; if (!seen)                   begin failures++; $display("FAIL wrap_done got=timeout exp=pulse"); end
        checks++; if (beats !== 4)             begin failures++; $display("FAIL wrap_beats got=%0d exp=4", beats); end
        checks++; if (exp_addr_q.size() !== 0) begin failures++; $display("FAIL wrap_addr_left got=%0d exp=0", exp_addr_q.size()); end
    endtask

    task automatic test_zero();
        int dones;
        clear_sb();
        tick();
        start_fetch(8'h22, 8'd0, 1'b0);
        @(negedge clk);
        checks++; if (bus.fetch_done_o !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", bus.fetch_done_o); end
        dones = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.fetch_busy_o !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", bus.fetch_busy_o); end
            checks++; if (bus.mem_req_o !== 1'b0)    begin failures++; $display("FAIL zero_req got=%b exp=0", bus.mem_req_o); end
            @(negedge clk);
            if (bus.fetch_done_o) dones++;
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_start_while_busy();
        bit seen;
        int issued_at_done;
        clear_sb();
        bus.class_hv_ready_i = 1'b1;
        tick();
        start_fetch(8'h80, 8'd4, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.fetch_done_o) seen = 1'b1;
            else begin
                tick();
                bus.class_hv_ready_i = 1'($urandom_range(0, 1));
                if (i == 0 || i == 1) begin
                    bus.fetch_start_i = 1'b1;
                    bus.num_class_i   = 8'd7;
                    bus.base_addr_i   = 8'h33;
                end else begin
                    bus.fetch_start_i = 1'b0;
                end
            end
        end
        checks++; if (!seen)       begin failures++; $display("FAIL busy_start_done got=timeout exp=pulse"); end
        checks++; if (beats !== 4) begin failures++; $display("FAIL busy_start_beats got=%0d exp=4", beats); end
        issued_at_done = issued;
        bus.class_hv_ready_i = 1'b1;
        repeat (4) tick();
        checks++; if (issued !== 4 || issued_at_done !== 4) begin failures++; $display("FAIL busy_start_reads got=%0d exp=4", issued); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_sb();
        bus.class_hv_ready_i = 1'b1;
        tick();
        start_fetch(8'h20, 8'd6, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (beats >= 2) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rmid_beat2 got=%0d exp=2", beats); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_sb();
        @(negedge clk);
        checks++; if (bus.fetch_busy_o !== 1'b0)     begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.fetch_busy_o); end
        checks++; if (bus.mem_req_o !== 1'b0)        begin failures++; $display("FAIL rmid_req got=%b exp=0", bus.mem_req_o); end
        checks++; if (bus.class_hv_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bus.class_hv_valid_o); end
        checks++; if (bus.fetch_done_o !== 1'b0)     begin failures++; $display("FAIL rmid_done got=%b exp=0", bus.fetch_done_o); end
        checks++; if (bus.class_hv_o !== '0)         begin failures++; $display("FAIL rmid_hv got=%0h exp=0", bus.class_hv_o[31:0]); end
        tick();
        start_fetch(8'h50, 8'd2, 1'b1);
        wait_done(50, seen);
        checks++; if (!seen)                 begin failures++; $display("FAIL rmid_restart_done got=timeout exp=pulse"); end
        checks++; if (beats !== 2)           begin failures++; $display("FAIL rmid_restart_beats got=%0d exp=2", beats); end
        checks++; if (exp_hv_q.size() !== 0) begin failures++; $display("FAIL rmid_restart_left got=%0d exp=0", exp_hv_q.size()); end
    endtask

    initial begin
        bus.fetch_start_i    = 1'b0;
        bus.num_class_i      = '0;
        bus.base_addr_i      = '0;
        bus.class_hv_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_start_while_busy();
        test_reset_mid();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
